// File: rtl/ysyx_23060124_icache_pkg.sv
// Shared types and constants for the instruction cache: FSM encoding, AXI
// burst constants and address-field width helpers.
package ysyx_23060124_icache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_AR     = 2'd2,
      ST_R      = 2'd3
   } icache_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   localparam int BYTE_BITS = 2;

   function automatic int offset_bits(input int words);
      return $clog2(words);
   endfunction

   function automatic int index_bits(input int lines);
      return $clog2(lines);
   endfunction

   // Whatever remains of the 32-bit address above index and word offset.
   function automatic int tag_bits(input int lines, input int words);
      return 32 - BYTE_BITS - offset_bits(words) - index_bits(lines);
   endfunction

endpackage

// File: rtl/ysyx_23060124_icache_if.sv
// AXI read-address and read-data channels between the icache (master) and
// the memory side (slave).
interface ysyx_23060124_icache_if;
   // A beat transfers on a rising edge where valid and ready are both high;
   // once valid is raised the sender keeps it and its payload stable until
   // that edge, and ready never depends on valid falling.
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;

   modport master (
      output arvalid, araddr, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/ysyx_23060124_icache_array.sv
// Direct-mapped storage: data and tag arrays (no reset), per-line valid bits,
// one refill write port and a combinational lookup/read port.
module ysyx_23060124_icache_array
   import ysyx_23060124_icache_pkg::*;
#(
   parameter  int LINES = 16,
   parameter  int WORDS = 4,
   localparam int IW    = index_bits(LINES),
   localparam int OW    = offset_bits(WORDS),
   localparam int TW    = tag_bits(LINES, WORDS)
) (
   input  logic          clock,
   input  logic          rst_n_sync,
   input  logic [IW-1:0] rd_index,
   input  logic [OW-1:0] rd_word,
   input  logic [TW-1:0] rd_tag,
   output logic          hit,
   output logic [31:0]   rd_data,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_index,
   input  logic [OW-1:0] wr_word,
   input  logic [31:0]   wr_data,
   input  logic          fill_done,
   input  logic [TW-1:0] wr_tag,
   input  logic          inval_all
);

   logic [31:0]    data_mem [LINES][WORDS];
   logic [TW-1:0]  tag_mem  [LINES];
   logic [LINES-1:0] valid_q;

   always_ff @(posedge clock) begin
      if (wr_en)     data_mem[wr_index][wr_word] <= wr_data;
      if (fill_done) tag_mem[wr_index] <= wr_tag;
   end

   // Invalidate-all outranks the fill so a flush racing the last beat wins.
   always_ff @(posedge clock or negedge rst_n_sync) begin
      if (!rst_n_sync)    valid_q <= '0;
      else if (inval_all) valid_q <= '0;
      else if (fill_done) valid_q[wr_index] <= 1'b1;
   end

   assign hit     = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
   assign rd_data = data_mem[rd_index][rd_word];

endmodule

// File: rtl/ysyx_23060124_icache.sv
// Direct-mapped instruction cache with AXI burst refill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module ysyx_23060124_icache
   import ysyx_23060124_icache_pkg::*;
#(
   parameter int ICACHE_LINES = 16,
   parameter int ICACHE_WORDS = 4
) (
   input  logic                      clock,
   input  logic                      rst_n_sync,
   input  logic                      req,
   input  logic [31:0]               req_addr,
   input  logic                      fence_i,
   output logic [31:0]               icache_ins,
   output logic                      cache_valid,
   ysyx_23060124_icache_if.master    axi,
   output icache_state_e             dbg_state
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]               hit_cnt,
   output logic [31:0]               miss_cnt
`endif
);

   localparam int IW      = index_bits(ICACHE_LINES);
   localparam int OW      = offset_bits(ICACHE_WORDS);
   localparam int TW      = tag_bits(ICACHE_LINES, ICACHE_WORDS);
   localparam int IDX_LSB = BYTE_BITS + OW;
   localparam int TAG_LSB = IDX_LSB + IW;

   icache_state_e state_q, state_d;
   logic [31:0]   addr_q;
   logic [OW-1:0] beat_q;
   logic [31:0]   ins_q;
   logic          hit;
   logic [31:0]   rd_data;
   logic          beat_wr;
   logic          fill_done;

   logic [TW-1:0] req_tag;
   logic [IW-1:0] req_index;
   logic [OW-1:0] req_word;

   assign req_tag   = addr_q[31:TAG_LSB];
   assign req_index = addr_q[TAG_LSB-1:IDX_LSB];
   assign req_word  = addr_q[IDX_LSB-1:BYTE_BITS];

   assign beat_wr   = (state_q == ST_R) && axi.rvalid;
   assign fill_done = beat_wr && axi.rlast;

   ysyx_23060124_icache_array #(
      .LINES (ICACHE_LINES),
      .WORDS (ICACHE_WORDS)
   ) u_array (
      .clock      (clock),
      .rst_n_sync (rst_n_sync),
      .rd_index   (req_index),
      .rd_word    (req_word),
      .rd_tag     (req_tag),
      .hit        (hit),
      .rd_data    (rd_data),
      .wr_en      (beat_wr),
      .wr_index   (req_index),
      .wr_word    (beat_q),
      .wr_data    (axi.rdata),
      .fill_done  (fill_done),
      .wr_tag     (req_tag),
      .inval_all  (fence_i)
   );

   always_ff @(posedge clock or negedge rst_n_sync) begin
      if (!rst_n_sync) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cache_valid = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (hit) begin
               cache_valid = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_AR;
            end
         end
         ST_AR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) state_d = ST_R;
         end
         ST_R: begin
            axi.rready = 1'b1;
            if (axi.rvalid && axi.rlast) state_d = ST_LOOKUP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Burst fields depend only on the latched address, so they are stable in AR.
   assign axi.araddr  = {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
   assign axi.arlen   = 8'(ICACHE_WORDS - 1);
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;

   always_ff @(posedge clock or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         addr_q <= '0;
         beat_q <= '0;
         ins_q  <= '0;
      end else begin
         if (state_q == ST_IDLE && req) addr_q <= req_addr;
         if (state_q == ST_AR)          beat_q <= '0;
         else if (beat_wr)              beat_q <= beat_q + OW'(1);
         if (cache_valid)               ins_q  <= rd_data;
      end
   end

   assign icache_ins = cache_valid ? rd_data : ins_q;
   assign dbg_state  = state_q;

   // Response code and byte offset carry no information for this cache.
   logic unused_bits;
   assign unused_bits = ^{addr_q[BYTE_BITS-1:0], (axi.rresp == AXI_RESP_OKAY)};

`ifdef ICACHE_PERF_EN
   // first_q separates a fresh lookup from the re-lookup after a refill.
   logic first_q;

   always_ff @(posedge clock or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         first_q  <= 1'b0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (state_q == ST_IDLE && req) first_q <= 1'b1;
         else if (fill_done)            first_q <= 1'b0;
         if (state_q == ST_LOOKUP && hit && first_q) hit_cnt  <= hit_cnt + 32'd1;
         if (state_q == ST_LOOKUP && !hit)           miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_23060124_icache.sv
// Scoreboard bench for the icache: random fetches against a memory-image and
// line-occupancy model, with an AXI slave that stalls, gaps and injects flushes.
module tb_ysyx_23060124_icache;
   import ysyx_23060124_icache_pkg::*;

   localparam int LINES      = 16;
   localparam int WORDS      = 4;
   localparam int LINE_BYTES = WORDS * 4;

   logic          clock = 1'b0;
   logic          rst_n_sync;
   logic          req;
   logic [31:0]   req_addr;
   logic          fence_drv;
   logic          fence_slv;
   logic          fence_i;
   logic [31:0]   icache_ins;
   logic          cache_valid;
   icache_state_e dbg_state;
`ifdef ICACHE_PERF_EN
   logic [31:0]   hit_cnt;
   logic [31:0]   miss_cnt;
`endif

   ysyx_23060124_icache_if axi();

   assign fence_i = fence_drv | fence_slv;

   ysyx_23060124_icache #(
      .ICACHE_LINES (LINES),
      .ICACHE_WORDS (WORDS)
   ) dut (
      .clock       (clock),
      .rst_n_sync  (rst_n_sync),
      .req         (req),
      .req_addr    (req_addr),
      .fence_i     (fence_i),
      .icache_ins  (icache_ins),
      .cache_valid (cache_valid),
      .axi         (axi.master),
      .dbg_state   (dbg_state)
`ifdef ICACHE_PERF_EN
      ,
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt)
`endif
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- memory image and reference model ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h3000_0000: return 32'h0000_0013;
         32'h3000_0004: return 32'h0000_0093;
         32'h3000_0008: return 32'h0000_0113;
         32'h3000_000C: return 32'h0000_0193;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
      endcase
   endfunction

   bit          m_valid [LINES];
   logic [31:0] m_tag   [LINES];
   int          m_hit  = 0;
   int          m_miss = 0;

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic [31:0] last_ins = '0;
   bit          prev_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (!rst_n_sync) begin
         last_ins   = '0;
         prev_valid = 1'b0;
      end else if (cache_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_valid: got 0x%08h expected no delivery", icache_ins);
         end else begin
            check("icache_ins", icache_ins, exp_q.pop_front());
         end
         last_ins   = icache_ins;
         prev_valid = 1'b1;
         done_cnt++;
         done_cyc   = cyc;
      end else begin
         if (prev_valid) check("ins_hold", icache_ins, last_ins);
         prev_valid = 1'b0;
      end
   end

   // ---------------- AXI slave model ----------------
   int          ar_delay_k  = 0;
   int          gap_k       = 0;
   int          abort_at_k  = -1;
   bit          fence_last_k = 1'b0;
   logic [31:0] cur_addr    = '0;
   int          ar_cnt      = 0;
   bit          aborted     = 1'b0;

   initial begin
      bit          ar_pend, in_beats, ar_fire, r_fire;
      int          wait_n, beat;
      logic [31:0] line_a, held_addr;
      logic [7:0]  held_len;
      ar_pend = 0; in_beats = 0; wait_n = 0; beat = 0; line_a = '0;
      held_addr = '0; held_len = '0;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
      axi.rresp = '0; axi.rlast = 1'b0; fence_slv = 1'b0;
      forever begin
         @(negedge clock);
         ar_fire = axi.arvalid && axi.arready;
         r_fire  = axi.rvalid && axi.rready;
         if (!rst_n_sync) begin
            ar_pend  = 0;
            in_beats = 0;
         end else begin
            if (axi.arvalid) begin
               if (!ar_pend) begin
                  ar_pend   = 1;
                  wait_n    = 0;
                  held_addr = axi.araddr;
                  held_len  = axi.arlen;
               end else begin
                  check("araddr_stable", axi.araddr, held_addr);
                  check("arlen_stable", 32'(axi.arlen), 32'(held_len));
               end
            end
            if (ar_fire) begin
               check("araddr", axi.araddr, cur_addr & ~32'(LINE_BYTES - 1));
               check("arlen", 32'(axi.arlen), 32'(WORDS - 1));
               check("arsize", 32'(axi.arsize), 32'h2);
               check("arburst", 32'(axi.arburst), 32'h1);
               ar_cnt++;
               line_a   = axi.araddr;
               beat     = 0;
               in_beats = 1;
               ar_pend  = 0;
            end
            if (r_fire) begin
               beat++;
               if (axi.rlast) in_beats = 0;
            end
         end
         @(posedge clock);
         #1;
         fence_slv = 1'b0;
         if (!rst_n_sync) begin
            axi.arready = 1'b0;
            axi.rvalid  = 1'b0;
            axi.rlast   = 1'b0;
         end else begin
            axi.arready = ar_pend && (wait_n >= ar_delay_k);
            if (ar_pend) wait_n++;
            if (!in_beats) begin
               axi.rvalid = 1'b0;
               axi.rlast  = 1'b0;
            end else if (!(axi.rvalid && !r_fire)) begin
               if (abort_at_k >= 0 && beat == abort_at_k) begin
                  axi.rvalid = 1'b0;
                  axi.rlast  = 1'b0;
                  aborted    = 1'b1;
               end else if ($urandom_range(0, gap_k) == 0) begin
                  axi.rvalid = 1'b1;
                  axi.rdata  = mem_word(line_a + 32'(4 * beat));
                  axi.rlast  = (beat == WORDS - 1);
                  axi.rresp  = 2'($urandom_range(0, 3));
                  if (axi.rlast && fence_last_k) begin
                     fence_slv    = 1'b1;
                     fence_last_k = 1'b0;
                  end
               end else begin
                  axi.rvalid = 1'b0;
                  axi.rlast  = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_fence();
      fence_drv = 1'b1;
      step();
      fence_drv = 1'b0;
      model_clear();
   endtask

   task automatic apply_reset();
      rst_n_sync = 1'b0;
      step();
      exp_q.delete();
      model_clear();
      m_hit  = 0;
      m_miss = 0;
      rst_n_sync = 1'b1;
      step();
   endtask

   task automatic do_fetch(input logic [31:0] addr, input bit f_last, input bit f_lookup,
                           input int ar_dly, input int gap);
      int idx, ar_start, done_start, req_cyc, n, exp_ars;
      logic [31:0] tag;
      bit hit_p;
      idx     = int'((addr / LINE_BYTES) % LINES);
      tag     = addr / (LINE_BYTES * LINES);
      hit_p   = m_valid[idx] && (m_tag[idx] == tag);
      exp_ars = hit_p ? 0 : (f_last ? 2 : 1);
      exp_q.push_back(mem_word(addr));
      ar_delay_k   = ar_dly;
      gap_k        = gap;
      fence_last_k = f_last && !hit_p;
      cur_addr     = addr;
      ar_start     = ar_cnt;
      done_start   = done_cnt;
      req      = 1'b1;
      req_addr = addr;
      req_cyc  = cyc;
      step();
      req      = 1'b0;
      req_addr = $urandom;
      if (f_lookup) begin
         fence_drv = 1'b1;
         step();
         fence_drv = 1'b0;
      end
      n = 0;
      while (done_cnt == done_start && n < 400) begin
         step();
         n++;
      end
      if (done_cnt == done_start) begin
         n_checks++;
         n_err++;
         $display("FAIL fetch_timeout: no cache_valid for addr 0x%08h after %0d cycles", addr, n);
         apply_reset();
      end else begin
         check("ar_count", 32'(ar_cnt - ar_start), 32'(exp_ars));
         if (hit_p) check("hit_latency", 32'(done_cyc - req_cyc), 32'd1);
         if (f_lookup) model_clear();
         if (hit_p) m_hit++;
         else begin
            if (f_last) model_clear();
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_miss += exp_ars;
         end
      end
      fence_last_k = 1'b0;
   endtask

   task automatic reset_mid_refill(input logic [31:0] addr);
      int n;
      abort_at_k = 2;
      aborted    = 1'b0;
      cur_addr   = addr;
      ar_delay_k = 0;
      gap_k      = 0;
      req      = 1'b1;
      req_addr = addr;
      step();
      req = 1'b0;
      n = 0;
      while (!aborted && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!aborted) begin
         n_checks++;
         n_err++;
         $display("FAIL abort_timeout: refill never reached beat 2 after %0d cycles", n);
      end
      step();
      rst_n_sync = 1'b0;
      #2;
      check("rst_mid_arvalid", 32'(axi.arvalid), 32'd0);
      check("rst_mid_rready", 32'(axi.rready), 32'd0);
      check("rst_mid_cache_valid", 32'(cache_valid), 32'd0);
      check("rst_mid_icache_ins", icache_ins, 32'd0);
      check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
      abort_at_k = -1;
      aborted    = 1'b0;
      exp_q.delete();
      model_clear();
      m_hit  = 0;
      m_miss = 0;
      step();
      rst_n_sync = 1'b1;
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] addr;
      rst_n_sync = 1'b0;
      req        = 1'b0;
      req_addr   = '0;
      fence_drv  = 1'b0;
      model_clear();
      repeat (3) step();
      check("rst_cache_valid", 32'(cache_valid), 32'd0);
      check("rst_arvalid", 32'(axi.arvalid), 32'd0);
      check("rst_rready", 32'(axi.rready), 32'd0);
      check("rst_icache_ins", icache_ins, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n_sync = 1'b1;
      step();

      do_fetch(32'h3000_0000, 0, 0, 0, 0);   // cold miss
      do_fetch(32'h3000_0008, 0, 0, 0, 0);   // hit in the same line
      do_fetch(32'h3000_0100, 0, 0, 0, 0);   // conflict evicts line 0
      do_fetch(32'h3000_0000, 0, 0, 0, 0);   // misses again
      pulse_fence();
      do_fetch(32'h3000_0004, 0, 0, 0, 0);   // miss after flush
      pulse_fence();
      do_fetch(32'h3000_000C, 1, 0, 0, 0);   // flush on last beat: two refills
      do_fetch(32'h3000_0000, 0, 0, 0, 0);   // now resident
      do_fetch(32'h3000_0004, 0, 1, 0, 0);   // flush during a hitting lookup
      do_fetch(32'h3000_0008, 0, 0, 0, 0);   // flushed, so misses
      do_fetch(32'h3000_0240, 0, 0, 5, 3);   // stalled AR and gapped beats
      do_fetch(32'h3000_0244, 0, 0, 0, 0);
      reset_mid_refill(32'h3000_0380);
      do_fetch(32'h3000_0380, 0, 0, 0, 0);   // line abandoned by reset misses
      do_fetch(32'h3000_0384, 0, 0, 0, 0);

      for (int i = 0; i < 150; i++) begin
         addr = 32'h3000_0000 | (32'($urandom_range(0, 3)) << 8)
                              | (32'($urandom_range(0, LINES - 1)) << 4)
                              | (32'($urandom_range(0, WORDS - 1)) << 2);
         if ($urandom_range(0, 9) == 0) pulse_fence();
         do_fetch(addr, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (3) step();
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
`ifdef ICACHE_PERF_EN
      check("hit_cnt", hit_cnt, 32'(m_hit));
      check("miss_cnt", miss_cnt, 32'(m_miss));
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
